// File: rtl/eth_irq_gateway.sv
`default_nettype none
// ============================================================================
// eth_irq_gateway : per-source gateways + priority arbiter with claim/complete
// Revision 1.0
// ============================================================================
module eth_irq_gateway #(
  parameter int num_src_p    = 2,
  parameter int prio_width_p = 3,
  parameter int id_width_p   = $clog2(num_src_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [num_src_p-1:0]    irq_i,
  input  logic                    prio_v_i,
  input  logic [id_width_p-1:0]   prio_id_i,
  input  logic [prio_width_p-1:0] prio_i,
  input  logic                    enable_v_i,
  input  logic [num_src_p-1:0]    enable_i,
  input  logic                    threshold_v_i,
  input  logic [prio_width_p-1:0] threshold_i,
  input  logic                    claim_v_i,
  output logic                    claim_v_o,
  output logic [id_width_p-1:0]   claim_id_o,
  input  logic                    complete_v_i,
  input  logic [id_width_p-1:0]   complete_id_i,
  output logic [num_src_p-1:0]    pending_o,
  output logic                    eip_o
);

  typedef enum logic [1:0] {
    GW_IDLE     = 2'd0,
    GW_PENDING  = 2'd1,
    GW_INFLIGHT = 2'd2
  } gw_state_e;

  gw_state_e                 state_q     [num_src_p];
  gw_state_e                 state_d     [num_src_p];
  logic [prio_width_p-1:0]   prio_q      [num_src_p];
  logic [prio_width_p-1:0]   prio_d      [num_src_p];
  logic [num_src_p-1:0]      enable_q,    enable_d;
  logic [prio_width_p-1:0]   threshold_q, threshold_d;
  logic                      eip_q,       eip_d;
  logic                      claim_v_q,   claim_v_d;
  logic [id_width_p-1:0]     claim_id_q,  claim_id_d;

  logic [num_src_p-1:0]      eligible;
  logic                      win_found;
  logic [prio_width_p-1:0]   win_prio;
  logic [id_width_p-1:0]     win_id;

  always_comb begin
    eligible  = '0;
    pending_o = '0;
    for (int k = 0; k < num_src_p; k++) begin
      pending_o[k] = (state_q[k] == GW_PENDING);
      eligible[k]  = (state_q[k] == GW_PENDING) && enable_q[k] &&
                     (prio_q[k] > threshold_q);
    end
  end

  // Ascending scan with strict '>' keeps the lowest ID on priority ties.
  always_comb begin
    win_found = 1'b0;
    win_prio  = '0;
    win_id    = '0;
    for (int k = 0; k < num_src_p; k++) begin
      if (eligible[k] && (!win_found || (prio_q[k] > win_prio))) begin
        win_found = 1'b1;
        win_prio  = prio_q[k];
        win_id    = id_width_p'(k + 1);
      end
    end
  end

  always_comb begin
    enable_d    = enable_v_i ? enable_i : enable_q;
    threshold_d = threshold_v_i ? threshold_i : threshold_q;
    eip_d       = |eligible;
    claim_v_d   = claim_v_i;
    claim_id_d  = claim_v_i ? win_id : '0;
    for (int k = 0; k < num_src_p; k++) begin
      prio_d[k]  = prio_q[k];
      state_d[k] = state_q[k];
      if (prio_v_i && (prio_id_i == id_width_p'(k + 1))) begin
        prio_d[k] = prio_i;
      end
      case (state_q[k])
        GW_IDLE: begin
          if (irq_i[k]) state_d[k] = GW_PENDING;
        end
        GW_PENDING: begin
          if (claim_v_i && (win_id == id_width_p'(k + 1))) state_d[k] = GW_INFLIGHT;
        end
        GW_INFLIGHT: begin
          if (complete_v_i && (complete_id_i == id_width_p'(k + 1))) state_d[k] = GW_IDLE;
        end
        default: state_d[k] = GW_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      enable_q    <= '0;
      threshold_q <= '0;
      eip_q       <= 1'b0;
      claim_v_q   <= 1'b0;
      claim_id_q  <= '0;
      for (int k = 0; k < num_src_p; k++) begin
        state_q[k] <= GW_IDLE;
        prio_q[k]  <= '0;
      end
    end else begin
      enable_q    <= enable_d;
      threshold_q <= threshold_d;
      eip_q       <= eip_d;
      claim_v_q   <= claim_v_d;
      claim_id_q  <= claim_id_d;
      for (int k = 0; k < num_src_p; k++) begin
        state_q[k] <= state_d[k];
        prio_q[k]  <= prio_d[k];
      end
    end
  end

  assign eip_o      = eip_q;
  assign claim_v_o  = claim_v_q;
  assign claim_id_o = claim_id_q;

endmodule
`default_nettype wire
